// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default counts for the CS sequencer.
package spi_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, SETUP, ACTIVE, HOLD, GAP, CONT} cs_state_t;
    localparam bit CPHA_LEAD  = 1'b0;
    localparam bit CPHA_TRAIL = 1'b1;
    localparam bit CPOL_LOW   = 1'b0;
    localparam bit CPOL_HIGH  = 1'b1;
    localparam int DEF_SETUP  = 2;
    localparam int DEF_HOLD   = 1;
    localparam int DEF_GAP    = 3;
endpackage

// File: rtl/spi_cs_sync.sv
// spi_cs_sync: 2-flop synchroniser for the external select pin, resets to the inactive (high) level.
module spi_cs_sync (
    input  logic prescale_clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge prescale_clk)
        if (rst) {q, meta} <= 2'b11;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer: multi-CS SPI select sequencer (setup/hold/gap, CPHA lead) plus slave-select sync.
// Define SPI_CS_BURST_EN to add keep_cs and the CONT state for back-to-back transfers on one select.
module spi_cs_sequencer
    import spi_pkg::*;
#(
    parameter int NUM_CS = 4,
    parameter int CNT_W  = 8,
    parameter int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              prescale_clk,
    input  logic              rst,
    input  logic              master_slave,
    input  logic              start,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpha,
    input  logic              cpol,
    input  logic [CNT_W-1:0]  setup_cycles,
    input  logic [CNT_W-1:0]  hold_cycles,
    input  logic [CNT_W-1:0]  gap_cycles,
    input  logic              transfer_done,
    input  logic              cs_in,
`ifdef SPI_CS_BURST_EN
    input  logic              keep_cs,
`endif
    output logic [NUM_CS-1:0] cs_n,
    output logic              start_transfer,
    output logic              sclk_idle_lvl,
    output logic              busy,
    output logic              done,
    output logic              sel_err,
    output logic              slave_enable
);
    cs_state_t        state, nxt;
    logic [CNT_W:0]   cnt, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             lvl_d, st_d, done_d, err_d, cs_sync, sel_ok;
    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    assign sel_ok = int'(cs_sel) < NUM_CS;

    spi_cs_sync u_sync (.prescale_clk(prescale_clk), .rst(rst), .d(cs_in), .q(cs_sync));

    always_comb begin
        nxt    = state;
        cnt_d  = cnt;
        sel_d  = sel_q;
        lvl_d  = sclk_idle_lvl;
        st_d   = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state)
            IDLE: begin
                err_d = start && !sel_ok;
                if (start && master_slave && sel_ok) begin
                    nxt   = SETUP;
                    cnt_d = {1'b0, setup_cycles} + {{CNT_W{1'b0}}, cpha};
                    sel_d = cs_sel;
                    lvl_d = cpol;
                end
            end
            SETUP:
                if (cnt == '0) begin
                    nxt  = ACTIVE;
                    st_d = 1'b1;
                end else cnt_d = cnt - ONE;
            ACTIVE:
                if (transfer_done) begin
                    nxt   = HOLD;
                    cnt_d = {1'b0, hold_cycles};
`ifdef SPI_CS_BURST_EN
                    if (keep_cs) begin
                        nxt    = CONT;
                        done_d = 1'b1;
                    end
`endif
                end
            HOLD:
                if (cnt == '0) begin
                    nxt   = GAP;
                    cnt_d = {1'b0, gap_cycles};
                end else cnt_d = cnt - ONE;
            GAP:
                if (cnt == '0) begin
                    nxt    = IDLE;
                    done_d = 1'b1;
                end else cnt_d = cnt - ONE;
`ifdef SPI_CS_BURST_EN
            // Same select restarts immediately; anything else closes the burst and drops the start.
            CONT:
                if (start && cs_sel == sel_q) begin
                    nxt  = ACTIVE;
                    st_d = 1'b1;
                end else if (start || !keep_cs) begin
                    nxt   = HOLD;
                    cnt_d = {1'b0, hold_cycles};
                end
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge prescale_clk)
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sel_q          <= '0;
            cs_n           <= '1;
            start_transfer <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sel_err        <= 1'b0;
            sclk_idle_lvl  <= 1'b0;
            slave_enable   <= 1'b0;
        end else begin
            state          <= nxt;
            cnt            <= cnt_d;
            sel_q          <= sel_d;
            cs_n           <= (nxt == SETUP || nxt == ACTIVE || nxt == HOLD || nxt == CONT) ?
                              ~(NUM_CS'(1) << sel_d) : '1;
            start_transfer <= st_d;
            busy           <= nxt != IDLE && nxt != CONT;
            done           <= done_d;
            sel_err        <= err_d;
            sclk_idle_lvl  <= lvl_d;
            slave_enable   <= !master_slave && !cs_sync;
        end
endmodule
